// File: rtl/ysyx_23060096_alu_pkg.sv
// Shared definitions for the ALU issue/collect block: op codes, FSM states and default width.
package ysyx_23060096_alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/ysyx_23060096_alu_model.sv
// Combinational golden model of the npc ALU op contract (all arithmetic modulo 2^W).
module ysyx_23060096_alu_model
  import ysyx_23060096_alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] y
);

  logic [W-1:0] diff;

  // Decode the op; LT/EQ both derive from the same subtraction.
  always_comb begin
    diff = a - b;
    y    = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = diff;
      ALU_NOT: y = ~a;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_LT:  y = {{(W-1){1'b0}}, diff[W-1]};
      ALU_EQ:  y = {{(W-1){1'b0}}, (diff == '0)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060096_alu_issue.sv
// Issue/collect end of the npc ALU port: registers {op,A,B} toward the ALU, waits one
// settle cycle, captures alu_out and returns it over a valid/ready response channel.
// An accumulator holds the last captured result so commands can chain on it.
// Optional feature: ALU_ISSUE_CHECK_EN adds a golden model and flags mismatches on rsp_err.
module ysyx_23060096_alu_issue
  import ysyx_23060096_alu_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic             cmd_acc,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_op,
  input  logic [W-1:0]     alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [2:0]       rsp_op,
  output logic             rsp_err,
  output logic [CNT_W-1:0] done_cnt
);

  alu_state_t   state;
  logic [W-1:0] acc;

  // Ready is a pure function of state and rsp_ready so the sender never sees a loop.
  assign cmd_ready = (state == ST_IDLE) | ((state == ST_RESP) & rsp_ready);
  assign rsp_valid = (state == ST_RESP);

`ifdef ALU_ISSUE_CHECK_EN
  logic [W-1:0] exp_y;

  ysyx_23060096_alu_model #(.W(W)) u_model (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (exp_y)
  );
`else
  assign rsp_err = 1'b0;
`endif

  // Single FSM: ALU inputs only change on accept, so they stay glitch-free while settling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      rsp_data <= '0;
      rsp_op   <= '0;
      acc      <= '0;
      done_cnt <= '0;
`ifdef ALU_ISSUE_CHECK_EN
      rsp_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_op <= cmd_op;
            alu_a  <= cmd_acc ? acc : cmd_a;
            alu_b  <= cmd_b;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // acc follows the capture, so a back-to-back cmd_acc already sees this result.
          rsp_data <= alu_out;
          acc      <= alu_out;
          rsp_op   <= alu_op;
`ifdef ALU_ISSUE_CHECK_EN
          rsp_err  <= (alu_out != exp_y);
`endif
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            done_cnt <= done_cnt + 1'b1;
            if (cmd_valid) begin
              alu_op <= cmd_op;
              alu_a  <= cmd_acc ? acc : cmd_a;
              alu_b  <= cmd_b;
              state  <= ST_ISSUE;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060096_alu_issue.sv
// Scoreboard bench for ysyx_23060096_alu_issue; the golden model stands in for the ALU.
module tb_ysyx_23060096_alu_issue;
  import ysyx_23060096_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_acc;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b, alu_out, model_y;
  logic [2:0] alu_op;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [3:0] rsp_data;
  logic [2:0] rsp_op;
  logic [7:0] done_cnt;
  logic       alu_force;

`ifdef ALU_ISSUE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  typedef struct {
    logic [3:0] data;
    logic [2:0] op;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ysyx_23060096_alu_model #(.W(4)) u_alu (.a(alu_a), .b(alu_b), .op(alu_op), .y(model_y));
  assign alu_out = alu_force ? 4'h3 : model_y;

  ysyx_23060096_alu_issue #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_err(rsp_err), .done_cnt(done_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a command from a negedge and hold it until the DUT takes it.
  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic acc, input logic [3:0] exp, input logic err, input logic push);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_acc = acc;
    #1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      if (push) sb.push_back('{exp, op, err});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp();
    int t;
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!rsp_valid) check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk); t++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Monitor: pops one expected entry per response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rsp_unexpected: got data %0h op %0h, none expected", rsp_data, rsp_op);
        end else begin
          e = sb.pop_front();
          check("rsp_data", {28'd0, rsp_data}, {28'd0, e.data});
          check("rsp_op",   {29'd0, rsp_op},   {29'd0, e.op});
          check("rsp_err",  {31'd0, rsp_err},  {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_acc = 1'b0;
    rsp_ready = 1'b1; alu_force = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_done_cnt",  {24'd0, done_cnt},  32'd0);
    check("rst_alu_a",     {28'd0, alu_a},     32'd0);

    // Latency: ALU inputs one edge after accept, response one edge later.
    send(ALU_ADD, 4'h7, 4'h9, 1'b0, 4'h0, 1'b0, 1'b1);
    check("lat_alu_op",    {29'd0, alu_op},    {29'd0, ALU_ADD});
    check("lat_alu_a",     {28'd0, alu_a},     32'h7);
    check("lat_alu_b",     {28'd0, alu_b},     32'h9);
    check("lat_rsp_idle",  {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    // acc holds 7+9 = 0
    send(ALU_ADD, 4'hF, 4'h1, 1'b1, 4'h1, 1'b0, 1'b1);

    // Op vectors, back-to-back
    send(ALU_SUB, 4'h3, 4'h5, 1'b0, 4'hE, 1'b0, 1'b1);
    send(ALU_LT,  4'h3, 4'h5, 1'b0, 4'h1, 1'b0, 1'b1);
    send(ALU_EQ,  4'h5, 4'h5, 1'b0, 4'h1, 1'b0, 1'b1);
    send(ALU_NOT, 4'h5, 4'h0, 1'b0, 4'hA, 1'b0, 1'b1);
    send(ALU_XOR, 4'h6, 4'h3, 1'b0, 4'h5, 1'b0, 1'b1);
    send(ALU_OR,  4'h8, 4'h1, 1'b0, 4'h9, 1'b0, 1'b1);
    drain();
    check("pre_rst_done_cnt", {24'd0, done_cnt}, 32'd8);

    // Reset while a response is pending: response discarded.
    rsp_ready = 1'b0;
    send(ALU_ADD, 4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0);
    wait_rsp();
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_alu_a",     {28'd0, alu_a},     32'd0);
    check("mid_rst_alu_b",     {28'd0, alu_b},     32'd0);
    check("mid_rst_alu_op",    {29'd0, alu_op},    32'd0);
    check("mid_rst_done_cnt",  {24'd0, done_cnt},  32'd0);
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rsp_ready = 1'b1;
    // acc cleared by reset: 0 + 6
    send(ALU_ADD, 4'h9, 4'h6, 1'b1, 4'h6, 1'b0, 1'b1);
    drain();

    // Backpressure, then release with a new command in the same cycle.
    rsp_ready = 1'b0;
    send(ALU_SUB, 4'h3, 4'h5, 1'b0, 4'hE, 1'b0, 1'b1);
    wait_rsp();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ALU_OR; cmd_a = 4'h5; cmd_b = 4'hA; cmd_acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_rsp_data",  {28'd0, rsp_data},  32'hE);
      check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    d0 = done_cnt;
    rsp_ready = 1'b1;
    sb.push_back('{4'hF, ALU_OR, 1'b0});
    #1;
    check("b2b_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_done_cnt", {24'd0, done_cnt}, {24'd0, d0 + 8'd1});
    check("b2b_alu_op",   {29'd0, alu_op},   {29'd0, ALU_OR});
    drain();

    // Accumulator chaining: cmd_a ignored on the second command.
    send(ALU_ADD, 4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b1);
    send(ALU_ADD, 4'hF, 4'h2, 1'b1, 4'h4, 1'b0, 1'b1);
    drain();

    // Corrupted ALU output: AND F,0 should be 0, ALU returns 3.
    alu_force = 1'b1;
    send(ALU_AND, 4'hF, 4'h0, 1'b0, 4'h3, CHK, 1'b1);
    wait_rsp();
    drain();
    alu_force = 1'b0;

    check("final_done_cnt", {24'd0, done_cnt}, 32'd6);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
